fs_score_engine: RTL and testbench
==================================

FS_SCORE_ENGINE -- requirements
Module: fs_score_engine

Interface
REQ-001 SHALL have parameter PIX_W, default 8, pixel and score width in bits.
REQ-002 SHALL have parameter ARC_LEN, default 9, contiguous arc length; legal range 9..12, selecting FAST-9..FAST-12.
REQ-003 SHALL have parameter ADDR_W, default 15, score memory address width; depth is 2^ADDR_W.
REQ-004 SHALL have ports, in order: clock  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-005 SHALL have in_valid  in  1  request valid; in_ready  out  1  engine can accept.
REQ-006 SHALL have is_corner  in  1  candidate passed the corner test; ref_addr  in  ADDR_W  score write address.
REQ-007 SHALL have ref_pixel  in  PIX_W  centre pixel; adj_pixel  in  16*PIX_W  ring pixels, index i at bits [i*PIX_W +: PIX_W]; thres  in  PIX_W  threshold.
REQ-008 SHALL have score_valid  out  1  write pulse; score_addr  out  ADDR_W; score_out  out  PIX_W  written score.
REQ-009 SHALL have rd_addr  in  ADDR_W  and rd_data  out  PIX_W, the score read port.

Function
REQ-010 SHALL accept a request when in_valid && in_ready are both high at a rising edge, capturing all request inputs.
REQ-011 SHALL run an FSM IDLE -> EVAL -> WRITE -> IDLE; in_ready is high only in IDLE.
REQ-012 SHALL go IDLE -> WRITE on accept with is_corner=0, and write score 0.
REQ-013 SHALL go IDLE -> EVAL on accept with is_corner=1, then evaluate one arc start k=0..15 per cycle for exactly 16 cycles, then enter WRITE.
REQ-014 SHALL define the arc at k as ring indices (k+j) mod 16 for j=0..ARC_LEN-1; wrap from 15 to 0 is required.
REQ-015 SHALL compute the bright arc value as min_j(adj - ref) if every adj > ref + thres, else 0.
REQ-016 SHALL compute the dark arc value as min_j(ref - adj) if every adj < ref - thres, else 0.
REQ-017 SHALL use PIX_W+1 bit arithmetic for ref +/- thres, with no wrap.
REQ-018 SHALL take the arc score as max(bright, dark); the final score is the running maximum over all 16 arcs, cleared to 0 on accept.
REQ-019 SHALL, in WRITE, write the score to memory at the captured ref_addr and pulse score_valid for one cycle with score_addr and score_out driven.
REQ-020 SHALL meet these latencies from accept at edge T: non-corner write at edge T+1; corner write at edge T+17; in_ready high again the cycle after WRITE.
REQ-021 SHALL have a read port with one-cycle registered latency.
REQ-022 SHALL return the old data on a read and write to the same address in the same cycle (read-before-write).
REQ-023 SHALL give a score of 0 when is_corner=1 but no arc qualifies.
REQ-024 SHALL use a strict compare at thres=0, so equal pixels never qualify.

Reset
REQ-025 SHALL on reset: state = IDLE; in_ready = 1; score_valid = 0; score_addr = 0; score_out = 0; running max = 0; arc counter = 0.
REQ-026 SHALL on reset during EVAL or WRITE: abort the request; no memory write occurs in the reset cycle or afterwards.
REQ-027 SHALL NOT clear score memory contents on reset; rd_data is undefined until the first read after reset.

Structure
REQ-028 SHALL have a shared package fs_pkg holding the FSM state enum, NUM_ADJ=16, and the ARC_LEN legality bounds (9, 12).
REQ-029 SHALL have one sub-module, fs_score_mem: a simple dual-port RAM, one write port plus one registered read port, parameterised by PIX_W and ADDR_W.
REQ-030 SHALL keep the arc evaluator combinational inside fs_score_engine, indexed by the arc counter.

Verification
REQ-031 SHALL cover: ARC_LEN=9, ref=100, all adj=150, thres=20, is_corner=1, ref_addr=5 -> score_valid at T+17, score_out=50, later rd_addr=5 gives 50.
REQ-032 SHALL cover: adj[12..15] and adj[0..4]=30, others 100, ref=100, thres=10 -> score 70, via the wrapped arc.
REQ-033 SHALL cover: only 8 contiguous adj=200, ref=100, thres=10, is_corner=1 -> score 0; the same with ARC_LEN=12 and 11 bright -> 0.
REQ-034 SHALL cover: is_corner=0, ref_addr=7 -> write of 0 at T+1, in_ready low for exactly one cycle.
REQ-035 SHALL cover: reset asserted at the 5th EVAL cycle -> no score_valid, address keeps its prior score, in_ready=1 the cycle after reset.
REQ-036 SHALL cover: back-to-back requests with in_valid held high -> second accepted the cycle in_ready rises; a same-address read during WRITE returns the old value.

Source files
------------

// File: rtl/fs_pkg.sv
// fs_pkg: shared definitions for the FAST score engine.
//   NUM_ADJ            - number of Bresenham ring pixels around the centre
//   ARC_LEN_MIN/MAX    - legal contiguous-arc lengths (FAST-9 .. FAST-12)
//   fsState_t          - engine FSM state encoding
package fs_pkg;

    localparam int NUM_ADJ     = 16;
    localparam int ARC_LEN_MIN = 9;
    localparam int ARC_LEN_MAX = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        WRITE = 2'd2
    } fsState_t;

endpackage

// File: rtl/fs_score_mem.sv
// fs_score_mem: simple dual-port score RAM.
//   clock          - sole clock
//   wrEn/wrAddr/wrData - synchronous write port
//   rdAddr/rdData  - read port, one-cycle registered latency; a read and a
//                    write to the same address in one cycle return old data
// Contents are never cleared.
module fs_score_mem #(
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 15
) (
    input  logic              clock,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [PIX_W-1:0]  wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [PIX_W-1:0]  rdData
);

    logic [PIX_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (wrEn)
            mem[wrAddr] <= wrData;
        // Non-blocking read of the pre-edge contents gives read-before-write.
        rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/fs_score_engine.sv
// fs_score_engine: FAST corner score computation and score store.
//   clock, reset        - sole clock, synchronous active-high reset
//   in_valid/in_ready   - request handshake; ready only while idle
//   is_corner, ref_addr, ref_pixel, adj_pixel, thres - request payload
//   score_valid/score_addr/score_out - one-cycle score write pulse
//   rd_addr/rd_data     - score memory read port (1-cycle latency)
// A corner request sweeps the 16 possible arc starts, one per cycle, keeping
// the running maximum of the per-arc score; a non-corner writes 0 directly.
import fs_pkg::*;

module fs_score_engine #(
    parameter int PIX_W   = 8,
    parameter int ARC_LEN = 9,
    parameter int ADDR_W  = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     is_corner,
    input  logic [ADDR_W-1:0]        ref_addr,
    input  logic [PIX_W-1:0]         ref_pixel,
    input  logic [NUM_ADJ*PIX_W-1:0] adj_pixel,
    input  logic [PIX_W-1:0]         thres,
    output logic                     score_valid,
    output logic [ADDR_W-1:0]        score_addr,
    output logic [PIX_W-1:0]         score_out,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [PIX_W-1:0]         rd_data
);

    if (ARC_LEN < ARC_LEN_MIN || ARC_LEN > ARC_LEN_MAX) begin : gBadArcLen
        $error("fs_score_engine: ARC_LEN out of range");
    end

    fsState_t state, nextState;

    logic [NUM_ADJ-1:0][PIX_W-1:0] adjReg;
    logic [PIX_W-1:0]  refReg, thresReg;
    logic [ADDR_W-1:0] addrReg;
    logic [3:0]        arcCnt;
    logic [PIX_W-1:0]  runMax;

    logic accept;
    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;

    // ---- arc evaluator for start index arcCnt ----
    logic             brightOk, darkOk;
    logic [PIX_W-1:0] brightMin, darkMin, arcScore, candMax, pix;
    logic [3:0]       idx;
    logic [PIX_W:0]   refHi;

    always_comb begin
        brightOk  = 1'b1;
        darkOk    = 1'b1;
        brightMin = '1;
        darkMin   = '1;
        idx       = '0;
        pix       = '0;
        // One extra bit so ref+thres cannot wrap.
        refHi     = {1'b0, refReg} + {1'b0, thresReg};
        for (int j = 0; j < ARC_LEN; j++) begin
            idx = arcCnt + 4'(j);   // 4-bit add wraps 15 -> 0
            pix = adjReg[idx];
            if (!({1'b0, pix} > refHi))
                brightOk = 1'b0;
            // adj < ref - thres rewritten as adj + thres < ref: no underflow
            if (!(({1'b0, pix} + {1'b0, thresReg}) < {1'b0, refReg}))
                darkOk = 1'b0;
            // Differences only matter when the arc qualifies, in which case
            // they cannot wrap.
            if (PIX_W'(pix - refReg) < brightMin)
                brightMin = PIX_W'(pix - refReg);
            if (PIX_W'(refReg - pix) < darkMin)
                darkMin = PIX_W'(refReg - pix);
        end
        if (!brightOk) brightMin = '0;
        if (!darkOk)   darkMin   = '0;
        arcScore = (brightMin > darkMin) ? brightMin : darkMin;
        candMax  = (arcScore > runMax) ? arcScore : runMax;
    end

    // ---- FSM next state ----
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (in_valid) nextState = is_corner ? EVAL : WRITE;
            EVAL:    if (arcCnt == 4'd15) nextState = WRITE;
            WRITE:   nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // ---- state and datapath registers ----
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            arcCnt      <= '0;
            runMax      <= '0;
            score_valid <= 1'b0;
            score_addr  <= '0;
            score_out   <= '0;
        end else begin
            state       <= nextState;
            score_valid <= (nextState == WRITE);
            case (state)
                IDLE: if (accept) begin
                    adjReg   <= adj_pixel;
                    refReg   <= ref_pixel;
                    thresReg <= thres;
                    addrReg  <= ref_addr;
                    runMax   <= '0;
                    arcCnt   <= '0;
                    if (!is_corner) begin
                        score_addr <= ref_addr;
                        score_out  <= '0;
                    end
                end
                EVAL: begin
                    arcCnt <= arcCnt + 4'd1;
                    runMax <= candMax;
                    if (arcCnt == 4'd15) begin
                        score_addr <= addrReg;
                        score_out  <= candMax;
                    end
                end
                default: ;
            endcase
        end
    end

    // score_valid is high exactly while in WRITE; the reset term keeps an
    // aborted request from landing in memory on the reset edge.
    fs_score_mem #(
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W)
    ) uMem (
        .clock  (clock),
        .wrEn   (score_valid && !reset),
        .wrAddr (score_addr),
        .wrData (score_out),
        .rdAddr (rd_addr),
        .rdData (rd_data)
    );

endmodule

// File: tb/tb_fs_score_engine.sv
module tb_fs_score_engine;
    localparam int PIX_W  = 8;
    localparam int ADDR_W = 15;

    logic clock = 1'b0;
    logic reset, in_valid, is_corner;
    logic [ADDR_W-1:0]   ref_addr, rd_addr;
    logic [PIX_W-1:0]    ref_pixel, thres;
    logic [16*PIX_W-1:0] adj_pixel;

    logic rdy9, sv9, rdy12, sv12;
    logic [ADDR_W-1:0] sa9, sa12;
    logic [PIX_W-1:0]  so9, so12, rd9, rd12;

    fs_score_engine #(.PIX_W(PIX_W), .ARC_LEN(9), .ADDR_W(ADDR_W)) dut9 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy9),
        .is_corner(is_corner), .ref_addr(ref_addr), .ref_pixel(ref_pixel),
        .adj_pixel(adj_pixel), .thres(thres), .score_valid(sv9),
        .score_addr(sa9), .score_out(so9), .rd_addr(rd_addr), .rd_data(rd9));

    fs_score_engine #(.PIX_W(PIX_W), .ARC_LEN(12), .ADDR_W(ADDR_W)) dut12 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(rdy12),
        .is_corner(is_corner), .ref_addr(ref_addr), .ref_pixel(ref_pixel),
        .adj_pixel(adj_pixel), .thres(thres), .score_valid(sv12),
        .score_addr(sa12), .score_out(so12), .rd_addr(rd_addr), .rd_data(rd12));

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int shadow9[int];
    int shadow12[int];

    int a[16];
    int pendC, pendAddr, pendRef, pendTh;
    int pendAdj[16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference score straight from the arc rules, using unbounded ints.
    function automatic int model(input int refp, input int adj[16], input int th, input int len);
        int best = 0;
        for (int k = 0; k < 16; k++) begin
            bit bOk = 1, dOk = 1;
            int bMin = 1 << 20, dMin = 1 << 20, arc;
            for (int j = 0; j < len; j++) begin
                int p = adj[(k + j) % 16];
                if (!(p > refp + th)) bOk = 0;
                if (!(p < refp - th)) dOk = 0;
                if (p - refp < bMin) bMin = p - refp;
                if (refp - p < dMin) dMin = refp - p;
            end
            arc = 0;
            if (bOk && bMin > arc) arc = bMin;
            if (dOk && dMin > arc) arc = dMin;
            if (arc > best) best = arc;
        end
        return best;
    endfunction

    task automatic applyReq(input int c, input int addr, input int refp, input int th, input int adj[16]);
        is_corner = c[0];
        ref_addr  = ADDR_W'(addr);
        ref_pixel = PIX_W'(refp);
        thres     = PIX_W'(th);
        for (int i = 0; i < 16; i++) adj_pixel[i*PIX_W +: PIX_W] = PIX_W'(adj[i]);
        in_valid  = 1'b1;
    endtask

    // Issues one request (called at a negedge), checks write timing/data and
    // the ready gap, returns at the negedge after the WRITE cycle.
    task automatic runReq(input int c, input int addr, input int refp, input int th,
                          input int adj[16], input bit chainNext, input bit rdCheck,
                          output int got9);
        int lat, low, waitN, e9, e12, old9, old12;
        applyReq(c, addr, refp, th, adj);
        e9  = c ? model(refp, adj, th, 9)  : 0;
        e12 = c ? model(refp, adj, th, 12) : 0;
        waitN = 0;
        while (!rdy9 && waitN < 50) begin @(negedge clock); waitN++; end
        chk("ready_before_accept", rdy9, 1);
        @(posedge clock);
        lat = 0; low = 0;
        do begin
            @(negedge clock);
            lat++;
            if (lat == 1) begin
                if (chainNext) applyReq(pendC, pendAddr, pendRef, pendTh, pendAdj);
                else in_valid = 1'b0;
            end
            if (!rdy9) low++;
        end while (!sv9 && lat < 40);
        chk("write_latency", lat, c ? 17 : 1);
        chk("ready_low_cycles", low, c ? 17 : 1);
        chk("valid12", sv12, 1);
        chk("score_addr9", sa9, addr);
        chk("score_addr12", sa12, addr);
        chk("score_out9", so9, e9);
        chk("score_out12", so12, e12);
        got9 = so9;
        old9  = shadow9.exists(addr)  ? shadow9[addr]  : 0;
        old12 = shadow12.exists(addr) ? shadow12[addr] : 0;
        if (rdCheck) rd_addr = ADDR_W'(addr);
        shadow9[addr]  = e9;
        shadow12[addr] = e12;
        @(negedge clock);
        chk("valid_one_cycle", sv9, 0);
        chk("ready_after_write", rdy9, 1);
        if (rdCheck) begin
            chk("rd_during_write9", rd9, old9);
            chk("rd_during_write12", rd12, old12);
        end
    endtask

    task automatic readCheck(input int addr);
        rd_addr = ADDR_W'(addr);
        @(negedge clock);
        chk("read9", rd9, shadow9[addr]);
        chk("read12", rd12, shadow12[addr]);
    endtask

    initial begin
        int got, svSeen;
        reset = 1'b1; in_valid = 1'b0; is_corner = 1'b0; ref_addr = '0;
        ref_pixel = '0; thres = '0; adj_pixel = '0; rd_addr = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset_ready", rdy9, 1);
        chk("reset_valid", sv9, 0);
        chk("reset_addr", sa9, 0);
        chk("reset_score", so9, 0);
        chk("reset_score12", so12, 0);

        // uniform bright ring
        for (int i = 0; i < 16; i++) a[i] = 150;
        runReq(1, 5, 100, 20, a, 0, 0, got);
        chk("uniform_bright_50", got, 50);
        readCheck(5);

        // dark arc that wraps 12..15,0..4
        for (int i = 0; i < 16; i++) a[i] = (i >= 12 || i <= 4) ? 30 : 100;
        runReq(1, 6, 100, 10, a, 0, 0, got);
        chk("wrapped_dark_70", got, 70);

        // 8 contiguous bright: too short for either length
        for (int i = 0; i < 16; i++) a[i] = (i >= 3 && i <= 10) ? 200 : 100;
        runReq(1, 8, 100, 10, a, 0, 0, got);
        chk("short_arc_0", got, 0);

        // 11 contiguous bright: FAST-9 scores, FAST-12 does not (model: 0)
        for (int i = 0; i < 16; i++) a[i] = (i >= 2 && i <= 12) ? 200 : 100;
        runReq(1, 9, 100, 10, a, 0, 0, got);
        chk("eleven_bright_100", got, 100);

        // equal pixels at thres 0 never qualify
        for (int i = 0; i < 16; i++) a[i] = 77;
        runReq(1, 10, 77, 0, a, 0, 0, got);
        chk("equal_thres0", got, 0);

        // near-saturation: ref+thres beyond pixel range, ref-thres below 0
        for (int i = 0; i < 16; i++) a[i] = 255;
        runReq(1, 11, 250, 10, a, 0, 0, got);
        for (int i = 0; i < 16; i++) a[i] = 0;
        runReq(1, 12, 5, 10, a, 0, 0, got);

        // non-corner
        runReq(0, 7, 100, 10, a, 0, 0, got);
        readCheck(7);

        // reset in the 5th EVAL cycle must abort without a write
        for (int i = 0; i < 16; i++) a[i] = 10;
        applyReq(1, 5, 200, 5, a);
        @(posedge clock);
        @(negedge clock); in_valid = 1'b0;
        repeat (4) @(negedge clock);
        chk("eval_busy", rdy9, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("ready_after_reset", rdy9, 1);
        chk("valid_after_reset", sv9, 0);
        chk("score_after_reset", so9, 0);
        svSeen = 0;
        repeat (25) begin @(negedge clock); if (sv9 || sv12) svSeen++; end
        chk("no_write_after_reset", svSeen, 0);
        readCheck(5);

        // back-to-back with in_valid held; same-address read during WRITE
        for (int i = 0; i < 16; i++) pendAdj[i] = 220;
        pendC = 1; pendAddr = 6; pendRef = 100; pendTh = 30;
        for (int i = 0; i < 16; i++) a[i] = 0;
        runReq(0, 5, 100, 10, a, 1, 1, got);
        runReq(pendC, pendAddr, pendRef, pendTh, pendAdj, 0, 1, got);
        readCheck(6);

        // randomized requests
        for (int n = 0; n < 30; n++) begin
            int refp, th, len, st, addr, c;
            bit bright;
            refp = $urandom_range(0, 255);
            th   = $urandom_range(0, 40);
            for (int i = 0; i < 16; i++) a[i] = $urandom_range(0, 255);
            len = $urandom_range(6, 16);
            st  = $urandom_range(0, 15);
            bright = 1'($urandom_range(0, 1));
            for (int j = 0; j < len; j++)
                a[(st + j) % 16] = bright ? $urandom_range(refp, 255) : $urandom_range(0, refp);
            addr = 100 + $urandom_range(0, 15);
            c = ($urandom_range(0, 4) != 0) ? 1 : 0;
            runReq(c, addr, refp, th, a, 0, 0, got);
        end
        for (int i = 100; i < 116; i++)
            if (shadow9.exists(i)) readCheck(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
